// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2^BPC restoring divider with RISC-V semantics.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    abort any in-flight operation and discard its result
//   div_valid / div_ready    operand handshake; an operation is accepted on a
//                            rising edge where both are high
//   divw, div_signed         32-bit word mode (sign-extended results), signed mode
//   dividend, divisor        XLEN-bit operands
//   out_valid / out_ready    result handshake; the result is held stable while
//                            out_valid is high, and it is consumed on a rising
//                            edge where both are high
//   quotient, remainder      XLEN-bit results (registered)
//   div_zero                 result came from a divide-by-zero (qualified by out_valid)
//
// Optional feature: define DIV_EARLY_TERM_EN to skip the dividend's leading
// zeros, so small dividends finish in fewer CALC cycles.
module iter_divider #(
  parameter int XLEN = 64,
  parameter int BPC  = 1,
  parameter int W_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_zero
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN:0]   prem_q, prem_d;     // partial remainder, one bit wider than N
  logic [XLEN-1:0] dvd_q, dvd_d;       // dividend bits shift out the top, quotient bits shift in the bottom
  logic [XLEN-1:0] dsr_q, dsr_d;       // |divisor|
  logic [CW-1:0]   cnt_q, cnt_d;       // CALC cycles remaining
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            wmode_q, wmode_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] remo_q, remo_d;
  logic            dz_q, dz_d;

  // Accept-time decode
  logic            w_mode, a_sign, b_sign, b_zero, ovf;
  logic [XLEN-1:0] n_mask, min_neg, a_n, b_n, a_abs, b_abs, a_top;
  logic [CW-1:0]   n_bits, shamt, cnt_init;

  // One CALC cycle of BPC chained steps
  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_dvd, q_fix, r_fix;

  // Word-mode results are sign-extended from bit 31 regardless of div_signed.
  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic w);
    fit = v;
    if (w) begin
      for (int i = 32; i < XLEN; i++) fit[i] = v[31];
    end
  endfunction

  always_comb begin
    w_mode = (W_EN != 0) && divw;
    n_mask = '1;
    min_neg = '0;
    if (w_mode) begin
      for (int i = 32; i < XLEN; i++) n_mask[i] = 1'b0;
      min_neg[31] = 1'b1;
    end else begin
      min_neg[XLEN-1] = 1'b1;
    end
    n_bits = w_mode ? CW'(32) : CW'(XLEN);
    a_n    = dividend & n_mask;
    b_n    = divisor & n_mask;
    a_sign = div_signed && (w_mode ? dividend[31] : dividend[XLEN-1]);
    b_sign = div_signed && (w_mode ? divisor[31] : divisor[XLEN-1]);
    a_abs  = (a_sign ? (~a_n + 1'b1) : a_n) & n_mask;
    b_abs  = (b_sign ? (~b_n + 1'b1) : b_n) & n_mask;
    b_zero = (b_n == '0);
    ovf    = div_signed && (a_n == min_neg) && (b_n == n_mask);
    // Left-align the N-bit magnitude so the iteration always starts at bit XLEN-1.
    a_top  = w_mode ? (a_abs << (XLEN - 32)) : a_abs;
`ifdef DIV_EARLY_TERM_EN
    begin : lzc
      logic [CW-1:0] lz;
      lz = n_bits;
      for (int i = 0; i < XLEN; i++) begin
        if (a_top[i]) lz = CW'(XLEN - 1 - i);
      end
      shamt = CW'((int'(lz) / BPC) * BPC);
    end
`else
    shamt = '0;
`endif
    cnt_init = CW'((int'(n_bits) - int'(shamt)) / BPC);
    // A zero dividend still takes one CALC cycle.
    if (cnt_init == '0) cnt_init = CW'(1);
  end

  always_comb begin
    step_rem = prem_q;
    step_dvd = dvd_q;
    for (int i = 0; i < BPC; i++) begin
      step_rem = {step_rem[XLEN-1:0], step_dvd[XLEN-1]};
      step_dvd = {step_dvd[XLEN-2:0], 1'b0};
      if (step_rem >= {1'b0, dsr_q}) begin
        step_rem    = step_rem - {1'b0, dsr_q};
        step_dvd[0] = 1'b1;
      end
    end
    q_fix = qneg_q ? (~step_dvd + 1'b1) : step_dvd;
    r_fix = rneg_q ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    wmode_d = wmode_q;
    ready_d = ready_q;
    valid_d = valid_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    if (flush) begin
      state_d = IDLE;
      ready_d = 1'b1;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_valid) begin
            wmode_d = w_mode;
            qneg_d  = a_sign ^ b_sign;
            rneg_d  = a_sign;
            ready_d = 1'b0;
            if (b_zero) begin
              state_d = DONE;
              valid_d = 1'b1;
              quo_d   = '1;
              remo_d  = fit(a_n, w_mode);
              dz_d    = 1'b1;
            end else if (ovf) begin
              state_d = DONE;
              valid_d = 1'b1;
              quo_d   = fit(a_n, w_mode);
              remo_d  = '0;
              dz_d    = 1'b0;
            end else begin
              state_d = CALC;
              prem_d  = '0;
              dvd_d   = a_top << shamt;
              dsr_d   = b_abs;
              cnt_d   = cnt_init;
            end
          end
        end
        CALC: begin
          prem_d = step_rem;
          dvd_d  = step_dvd;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            valid_d = 1'b1;
            quo_d   = fit(q_fix, wmode_q);
            remo_d  = fit(r_fix, wmode_q);
            dz_d    = 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      wmode_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      wmode_q <= wmode_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign div_ready = ready_q;
  assign out_valid = valid_q;
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider (XLEN=64, BPC=1, W_EN=1): directed cases, randomized
// operations against a plain-arithmetic reference model, backpressure, flush
// and asynchronous reset during CALC.
module tb_iter_divider;
  localparam int XLEN = 64;
  localparam int BPC  = 1;

  logic            clk = 1'b0;
  logic            rst, flush, div_valid, divw, div_signed, out_ready;
  logic [XLEN-1:0] dividend, divisor, quotient, remainder;
  logic            div_ready, out_valid, div_zero;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  iter_divider #(.XLEN(XLEN), .BPC(BPC), .W_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid), .div_ready(div_ready),
    .divw(divw), .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  // Reference: RISC-V div/rem semantics with native arithmetic, latency from
  // the cycle-count rules.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic w,
                                input logic s, output logic [63:0] q, output logic [63:0] r,
                                output logic dz, output int lat);
    logic [31:0] a32, b32, q32, r32, m32;
    logic [63:0] m;
    int ia, ib, n, lz, cyc;
    longint la, lb;
    bit special;
    dz = 1'b0;
    special = 1'b0;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 0) begin
        q32 = '1; r32 = a32; dz = 1'b1; special = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 0; special = 1'b1;
      end else if (s) begin
        ia = $signed(a32); ib = $signed(b32);
        q32 = ia / ib; r32 = ia % ib;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 0) begin
        q = '1; r = a; dz = 1'b1; special = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 0; special = 1'b1;
      end else if (s) begin
        la = $signed(a); lb = $signed(b);
        q = la / lb; r = la % lb;
      end else begin
        q = a / b; r = a % b;
      end
    end
    n = w ? 32 : 64;
    cyc = n / BPC;
`ifdef DIV_EARLY_TERM_EN
    if (w) begin
      m32 = (s && a32[31]) ? -a32 : a32;
      m = {32'h0, m32};
    end else begin
      m = (s && a[63]) ? -a : a;
    end
    lz = n;
    for (int i = 0; i < n; i++) if (m[i]) lz = n - 1 - i;
    cyc = (n - lz + BPC - 1) / BPC;
    if (cyc < 1) cyc = 1;
`else
    m32 = '0; m = '0; lz = 0;
`endif
    lat = special ? 1 : cyc + 1;
  endfunction

  // Issue one op and wait for out_valid; result left pending (out_ready low).
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic w, input logic s,
                       output logic [63:0] q, output logic [63:0] r, output logic dz,
                       output int lat, output bit ready_low);
    int guard;
    guard = 0;
    while (!div_ready && guard < 300) begin
      @(posedge clk); #1; guard++;
    end
    dividend = a; divisor = b; divw = w; div_signed = s; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    lat = 1;
    ready_low = 1'b1;
    while (!out_valid && lat < 300) begin
      if (div_ready) ready_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (div_ready) ready_low = 1'b0;
    q = quotient; r = remainder; dz = div_zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; divw = 1'b0; div_signed = 1'b0;
    out_ready = 1'b0; dividend = '0; divisor = '0;
    #12;
    total++;
    if (div_ready !== 1'b1 || out_valid !== 1'b0 || div_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b valid=%b dz=%b required 1/0/0", div_ready, out_valid, div_zero);
    end
    total++;
    if (quotient !== '0 || remainder !== '0) begin
      bad++;
      $display("FAIL reset_data: q=%h r=%h required 0/0", quotient, remainder);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [63:0] q, r, eq, er;
    logic dz, edz;
    int lat, elat;
    bit rl;
    // 100 / 7 unsigned
    model(64'd100, 64'd7, 1'b0, 1'b0, eq, er, edz, elat);
    do_op(64'd100, 64'd7, 1'b0, 1'b0, q, r, dz, lat, rl);
    total++;
    if (q !== 64'd14 || r !== 64'd2) begin
      bad++; $display("FAIL div_100_7: q=%0d r=%0d required 14/2", q, r);
    end
    total++;
    if (lat !== elat || !rl) begin
      bad++; $display("FAIL lat_100_7: lat=%0d ready_low=%0b required %0d/1", lat, rl, elat);
    end
    release_result();
    // signed divw -7 / 2
    model(64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, eq, er, edz, elat);
    do_op(64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, q, r, dz, lat, rl);
    total++;
    if (q !== 64'hFFFF_FFFF_FFFF_FFFD || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++; $display("FAIL divw_m7_2: q=%h r=%h required fffffffffffffffd/ffffffffffffffff", q, r);
    end
    total++;
    if (lat !== elat) begin
      bad++; $display("FAIL lat_divw: lat=%0d required %0d", lat, elat);
    end
    release_result();
    // signed overflow
    do_op(64'h8000_0000_0000_0000, '1, 1'b0, 1'b1, q, r, dz, lat, rl);
    total++;
    if (q !== 64'h8000_0000_0000_0000 || r !== '0 || dz !== 1'b0 || lat !== 1) begin
      bad++; $display("FAIL overflow: q=%h r=%h dz=%b lat=%0d required 8000000000000000/0/0/1", q, r, dz, lat);
    end
    release_result();
    // divide by zero
    do_op(64'h1234, 64'h0, 1'b0, 1'b0, q, r, dz, lat, rl);
    total++;
    if (q !== '1 || r !== 64'h1234 || dz !== 1'b1 || lat !== 1) begin
      bad++; $display("FAIL div_zero: q=%h r=%h dz=%b lat=%0d required all-ones/1234/1/1", q, r, dz, lat);
    end
    release_result();
    // 5 / 1 (short under early termination)
    model(64'd5, 64'd1, 1'b0, 1'b0, eq, er, edz, elat);
    do_op(64'd5, 64'd1, 1'b0, 1'b0, q, r, dz, lat, rl);
    total++;
    if (q !== 64'd5 || r !== 64'd0 || lat !== elat) begin
      bad++; $display("FAIL div_5_1: q=%0d r=%0d lat=%0d required 5/0/%0d", q, r, lat, elat);
    end
    release_result();
  endtask

  task automatic test_random();
    logic [63:0] a, b, q, r, eq, er;
    logic w, s, dz, edz;
    int lat, elat;
    bit rl;
    for (int k = 0; k < 40; k++) begin
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 64'h8000_0000_0000_0000; b = '1; end
        2: begin a = 64'h0000_0000_8000_0000; b = 64'h0000_0000_FFFF_FFFF; end
        3: a = '0;
        4: a = -a;
        default: ;
      endcase
      model(a, b, w, s, eq, er, edz, elat);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      do_op(a, b, w, s, q, r, dz, lat, rl);
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      total++;
      if (q !== eq || r !== er || dz !== edz || lat !== elat || !rl) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h w=%b s=%b: q=%h r=%h dz=%b lat=%0d required q=%h r=%h dz=%b lat=%0d",
                 k, a, b, w, s, q, r, dz, lat, eq, er, edz, elat);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] q, r;
    logic dz;
    int lat;
    bit rl, stable;
    do_op(64'd1000, 64'd9, 1'b0, 1'b0, q, r, dz, lat, rl);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || quotient !== 64'd111 || remainder !== 64'd1 || div_ready !== 1'b0)
        stable = 1'b0;
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL backpressure_hold: valid=%b q=%0d r=%0d required 1/111/1", out_valid, quotient, remainder);
    end
    release_result();
    total++;
    if (div_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL backpressure_exit: ready=%b valid=%b required 1/0", div_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    logic [63:0] q, r, q_before;
    logic dz;
    int lat;
    bit rl, rose;
    q_before = quotient;
    dividend = 64'h0123_4567_89AB_CDEF; divisor = 64'd3; divw = 1'b0; div_signed = 1'b0;
    div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    div_valid = 1'b1;   // must be ignored on the flush edge
    @(posedge clk); #1;
    flush = 1'b0;
    div_valid = 1'b0;
    total++;
    if (div_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== q_before) begin
      bad++; $display("FAIL flush_exit: ready=%b valid=%b q=%h required 1/0/%h", div_ready, out_valid, quotient, q_before);
    end
    rose = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    total++;
    if (rose) begin
      bad++; $display("FAIL flush_no_result: out_valid rose=1 required 0");
    end
    do_op(64'd6, 64'd3, 1'b0, 1'b0, q, r, dz, lat, rl);
    total++;
    if (q !== 64'd2 || r !== 64'd0) begin
      bad++; $display("FAIL after_flush: q=%0d r=%0d required 2/0", q, r);
    end
    release_result();
  endtask

  task automatic test_rst_mid_calc();
    dividend = 64'hFFFF_0000_1234_5678; divisor = 64'd7; divw = 1'b0; div_signed = 1'b0;
    div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    total++;
    if (div_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_calc: ready=%b valid=%b q=%h r=%h dz=%b required 1/0/0/0/0",
               div_ready, out_valid, quotient, remainder, div_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (out_valid !== 1'b0 || div_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release: valid=%b ready=%b required 0/1", out_valid, div_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_rst_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
